// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester output arbiter.
// Holds the arbiter state enum, the source enum and the burst default.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/mux_arb_mux2.sv
// Day1 8-bit 2:1 data mux; y follows b when sel is high, else a.
// Ports: a, b (8-bit data in), sel (select), y (8-bit data out).
module mux_arb_mux2 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sel,
    output logic [7:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_arb.sv
// Two-requester arbiter feeding one registered output slot, with a burst
// limit so one source cannot starve the other for more than MAX_BURST beats.
// Ports: clk, reset (sync, active high); a_valid_i/a_data_i/a_ready_o and
// b_valid_i/b_data_i/b_ready_o requesters; y_valid_o/y_data_o/y_src_o
// output slot with y_ready_i from the consumer.
// Build option: define MUX_ARB_RR_EN for round-robin IDLE contention;
// otherwise A always wins contention from IDLE.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid_i,
    input  logic [7:0] a_data_i,
    output logic       a_ready_o,
    input  logic       b_valid_i,
    input  logic [7:0] b_data_i,
    output logic       b_ready_o,
    output logic       y_valid_o,
    output logic [7:0] y_data_o,
    output logic       y_src_o,
    input  logic       y_ready_i
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     state;
    logic [3:0] burst_cnt;
    src_t       last_src;

    logic       y_valid;
    logic [7:0] y_data;
    src_t       y_src;

    logic       grant_vld;
    src_t       grant;
    logic       load_en;
    logic       xfer;
    logic       owned;
    logic [3:0] cnt_next;
    logic [7:0] sel_data;

    // Grant selection; a grant is only ever issued to a valid requester.
    always_comb begin
        grant_vld = 1'b0;
        grant     = SRC_A;
        case (state)
            OWN_A: begin
                if (a_valid_i && (burst_cnt < BURST_LIM || !b_valid_i)) begin
                    grant_vld = 1'b1;
                    grant     = SRC_A;
                end else if (b_valid_i) begin
                    grant_vld = 1'b1;
                    grant     = SRC_B;
                end
            end
            OWN_B: begin
                if (b_valid_i && (burst_cnt < BURST_LIM || !a_valid_i)) begin
                    grant_vld = 1'b1;
                    grant     = SRC_B;
                end else if (a_valid_i) begin
                    grant_vld = 1'b1;
                    grant     = SRC_A;
                end
            end
            default: begin
                if (a_valid_i && b_valid_i) begin
                    grant_vld = 1'b1;
`ifdef MUX_ARB_RR_EN
                    grant = (last_src == SRC_A) ? SRC_B : SRC_A;
`else
                    grant = SRC_A;
`endif
                end else if (a_valid_i) begin
                    grant_vld = 1'b1;
                    grant     = SRC_A;
                end else if (b_valid_i) begin
                    grant_vld = 1'b1;
                    grant     = SRC_B;
                end
            end
        endcase
    end

    assign load_en = !y_valid || y_ready_i;
    // Reset suppresses any handshake in the reset cycle itself.
    assign xfer    = load_en && grant_vld && !reset;

    assign a_ready_o = xfer && (grant == SRC_A);
    assign b_ready_o = xfer && (grant == SRC_B);

    // Continuing an existing burst extends the count; a new owner restarts at 1.
    assign owned = (state == OWN_A && grant == SRC_A) ||
                   (state == OWN_B && grant == SRC_B);
    assign cnt_next = !owned ? 4'd1 :
                      (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;

    mux_arb_mux2 u_mux (
        .a   (a_data_i),
        .b   (b_data_i),
        .sel (grant == SRC_B),
        .y   (sel_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
            last_src  <= SRC_B;
            y_valid   <= 1'b0;
            y_data    <= 8'h00;
            y_src     <= SRC_A;
        end else begin
            if (xfer) begin
                y_valid   <= 1'b1;
                y_data    <= sel_data;
                y_src     <= grant;
                state     <= (grant == SRC_A) ? OWN_A : OWN_B;
                burst_cnt <= cnt_next;
                last_src  <= grant;
            end else begin
                if (y_ready_i) begin
                    y_valid <= 1'b0;
                end
                if (!a_valid_i && !b_valid_i) begin
                    state     <= IDLE;
                    burst_cnt <= 4'd0;
                end
            end
        end
    end

    assign y_valid_o = y_valid;
    assign y_data_o  = y_data;
    assign y_src_o   = y_src;

endmodule

// File: tb/tb_mux_arb.sv
// Directed self-checking bench for mux_arb (MAX_BURST = 4).
// Expectations follow MUX_ARB_RR_EN when the bench is built with it.
module tb_mux_arb;
    import mux_arb_pkg::*;

`ifdef MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       a_valid_i;
    logic [7:0] a_data_i;
    logic       a_ready_o;
    logic       b_valid_i;
    logic [7:0] b_data_i;
    logic       b_ready_o;
    logic       y_valid_o;
    logic [7:0] y_data_o;
    logic       y_src_o;
    logic       y_ready_i;

    int n_vec;
    int n_err;

    mux_arb #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid_i (a_valid_i),
        .a_data_i  (a_data_i),
        .a_ready_o (a_ready_o),
        .b_valid_i (b_valid_i),
        .b_data_i  (b_data_i),
        .b_ready_o (b_ready_o),
        .y_valid_o (y_valid_o),
        .y_data_o  (y_data_o),
        .y_src_o   (y_src_o),
        .y_ready_i (y_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        a_valid_i = 1'b0;
        a_data_i  = 8'h00;
        b_valid_i = 1'b0;
        b_data_i  = 8'h00;
        y_ready_i = 1'b0;
        tick();

        // Reset holds readies low even with a valid requester
        a_valid_i = 1'b1;
        a_data_i  = 8'hAA;
        #1;
        check("rst_ardy", 32'(a_ready_o), 32'd0);
        tick();
        check("rst_yvld", 32'(y_valid_o), 32'd0);
        check("rst_ydat", 32'(y_data_o), 32'h00);
        check("rst_ysrc", 32'(y_src_o), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_cnt", 32'(dut.burst_cnt), 32'd0);

        // Single A beat, one-cycle latency
        reset     = 1'b0;
        y_ready_i = 1'b1;
        #1;
        check("a1_ardy", 32'(a_ready_o), 32'd1);
        check("a1_brdy", 32'(b_ready_o), 32'd0);
        tick();
        a_valid_i = 1'b0;
        check("a1_yvld", 32'(y_valid_o), 32'd1);
        check("a1_ydat", 32'(y_data_o), 32'hAA);
        check("a1_ysrc", 32'(y_src_o), 32'd0);
        check("a1_state", 32'(dut.state), 32'(OWN_A));
        check("a1_cnt", 32'(dut.burst_cnt), 32'd1);
        tick();
        check("drain_yvld", 32'(y_valid_o), 32'd0);
        check("drain_ydat", 32'(y_data_o), 32'hAA);
        check("drain_state", 32'(dut.state), 32'(IDLE));
        check("drain_cnt", 32'(dut.burst_cnt), 32'd0);

        // Contention after an A transfer
        a_valid_i = 1'b1;
        a_data_i  = 8'h11;
        b_valid_i = 1'b1;
        b_data_i  = 8'h22;
        #1;
        check("ca_ardy", 32'(a_ready_o), 32'(!RR));
        check("ca_brdy", 32'(b_ready_o), 32'(RR));
        tick();
        check("ca_ysrc", 32'(y_src_o), 32'(RR));
        check("ca_ydat", 32'(y_data_o), RR ? 32'h22 : 32'h11);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();

        // Single B beat
        b_valid_i = 1'b1;
        b_data_i  = 8'h33;
        tick();
        b_valid_i = 1'b0;
        check("b1_ysrc", 32'(y_src_o), 32'd1);
        check("b1_ydat", 32'(y_data_o), 32'h33);
        tick();

        // Contention after a B transfer: A in both builds
        a_valid_i = 1'b1;
        a_data_i  = 8'h44;
        b_valid_i = 1'b1;
        b_data_i  = 8'h55;
        #1;
        check("cb_ardy", 32'(a_ready_o), 32'd1);
        check("cb_brdy", 32'(b_ready_o), 32'd0);
        tick();
        check("cb_ysrc", 32'(y_src_o), 32'd0);
        check("cb_ydat", 32'(y_data_o), 32'h44);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();

        // Continuous contention: AAAABBBBAA
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        a_valid_i = 1'b1;
        a_data_i  = 8'hA5;
        b_valid_i = 1'b1;
        b_data_i  = 8'hB5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("burst%0d_src", i), 32'(y_src_o),
                  32'((i / 4) % 2));
            check($sformatf("burst%0d_dat", i), 32'(y_data_o),
                  ((i / 4) % 2) != 0 ? 32'hB5 : 32'hA5);
        end
        check("burst_state", 32'(dut.state), 32'(OWN_A));
        check("burst_cnt", 32'(dut.burst_cnt), 32'd2);

        // Backpressure for three cycles
        y_ready_i = 1'b0;
        a_data_i  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d_ardy", i), 32'(a_ready_o), 32'd0);
            check($sformatf("stall%0d_brdy", i), 32'(b_ready_o), 32'd0);
            tick();
            check($sformatf("stall%0d_yvld", i), 32'(y_valid_o), 32'd1);
            check($sformatf("stall%0d_ydat", i), 32'(y_data_o), 32'hA5);
            check($sformatf("stall%0d_ysrc", i), 32'(y_src_o), 32'd0);
            check($sformatf("stall%0d_cnt", i), 32'(dut.burst_cnt), 32'd2);
        end
        y_ready_i = 1'b1;
        #1;
        check("rel_ardy", 32'(a_ready_o), 32'd1);
        tick();
        check("rel_ydat", 32'(y_data_o), 32'h5A);
        check("rel_cnt", 32'(dut.burst_cnt), 32'd3);

        // Reset during the third beat of an A burst
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        a_valid_i = 1'b1;
        a_data_i  = 8'hC1;
        tick();
        a_data_i = 8'hC2;
        tick();
        check("pre_cnt", 32'(dut.burst_cnt), 32'd2);
        reset    = 1'b1;
        a_data_i = 8'hC3;
        #1;
        check("mid_rst_ardy", 32'(a_ready_o), 32'd0);
        tick();
        check("mid_rst_yvld", 32'(y_valid_o), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst_cnt", 32'(dut.burst_cnt), 32'd0);
        check("mid_rst_last", 32'(dut.last_src), 32'(SRC_B));
        reset     = 1'b0;
        a_data_i  = 8'hD1;
        b_valid_i = 1'b1;
        b_data_i  = 8'hD2;
        #1;
        check("post_ardy", 32'(a_ready_o), 32'd1);
        check("post_brdy", 32'(b_ready_o), 32'd0);
        tick();
        check("post_yvld", 32'(y_valid_o), 32'd1);
        check("post_ysrc", 32'(y_src_o), 32'd0);
        check("post_ydat", 32'(y_data_o), 32'hD1);

        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
